// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and the downstream OR-reduction stage.
// MATRIX_ROWS/MATRIX_COLS are the default frame geometry; row_t and matrix_t describe
// one frame, and flatten() produces the bit layout used on the frame bus
// (row r at bits [r*COLS +: COLS]).
package matrix_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 16;

    typedef logic [MATRIX_COLS-1:0] row_t;
    typedef row_t [MATRIX_ROWS-1:0] matrix_t;

    // Width of a row index; a single-row frame still needs a one-bit index
    function automatic int idxWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Pack a frame into the flat bus layout, row 0 in the least significant bits
    function automatic logic [MATRIX_ROWS*MATRIX_COLS-1:0] flatten(input matrix_t m);
        logic [MATRIX_ROWS*MATRIX_COLS-1:0] flat;
        flat = '0;
        for (int r = 0; r < MATRIX_ROWS; r++) begin
            flat[r*MATRIX_COLS +: MATRIX_COLS] = m[r];
        end
        return flat;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// One ROWS x COLS frame store: synchronous single-row write, synchronous clear,
// and the whole frame visible at once on a flat read port.
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int ROWS = MATRIX_ROWS,
    parameter int COLS = MATRIX_COLS,
    parameter int RW   = idxWidth(ROWS)
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [RW-1:0]        row_i,
    input  logic [COLS-1:0]      data_i,
    output logic [ROWS*COLS-1:0] matrix_o
);

    logic [ROWS-1:0][COLS-1:0] bankRows_q;

    // Clear wins over a write so a reset never leaves stale rows behind
    always_ff @(posedge clk) begin
        if (clr_i) begin
            bankRows_q <= '0;
        end else if (we_i) begin
            bankRows_q[row_i] <= data_i;
        end
    end

    assign matrix_o = bankRows_q;

endmodule

// File: rtl/matrix_row_loader.sv
// Collects ROWS row words into a frame and hands complete frames downstream.
// Two banks ping-pong: one fills while the other is held for the consumer, so the
// input keeps taking one row per clock as long as a bank is free.
// Optional build macro: MATRIX_ROW_LOADER_LAST_CHECK_EN adds an s_last framing check
// (err_cnt / err_sticky); without it those outputs are tied to zero.
module matrix_row_loader
    import matrix_pkg::*;
#(
    parameter int ROWS = MATRIX_ROWS,
    parameter int COLS = MATRIX_COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      s_row,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [ROWS*COLS-1:0] m_matrix,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt,
    output logic                 err_sticky
);

    localparam int RW = idxWidth(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic                 wrSel_q, wrSel_d;
    logic                 rdSel_q, rdSel_d;
    logic [RW-1:0]        wrRow_q, wrRow_d;
    logic [1:0]           full_q, full_d;
    logic [15:0]          frameCnt_q, frameCnt_d;
    logic                 accept;
    logic                 consume;
    logic                 rowIsLast;
    logic [1:0]           bankWe;
    logic [ROWS*COLS-1:0] bankData [2];

    // Ready depends only on registered state, never on m_ready or s_valid
    assign s_ready   = !rst && !full_q[wrSel_q];
    assign accept    = s_valid && s_ready;
    assign m_valid   = full_q[rdSel_q];
    assign consume   = m_valid && m_ready;
    assign rowIsLast = (wrRow_q == LAST_ROW);
    assign m_matrix  = bankData[rdSel_q];
    assign frame_cnt = frameCnt_q;
    assign bankWe[0] = accept && !wrSel_q;
    assign bankWe[1] = accept &&  wrSel_q;

    for (genvar b = 0; b < 2; b++) begin : gBank
        matrix_bank #(
            .ROWS (ROWS),
            .COLS (COLS),
            .RW   (RW)
        ) uBank (
            .clk      (clk),
            .clr_i    (rst),
            .we_i     (bankWe[b]),
            .row_i    (wrRow_q),
            .data_i   (s_row),
            .matrix_o (bankData[b])
        );
    end

    // Bank bookkeeping and frame counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wrSel_q    <= 1'b0;
            rdSel_q    <= 1'b0;
            wrRow_q    <= '0;
            full_q     <= 2'b00;
            frameCnt_q <= 16'd0;
        end else begin
            wrSel_q    <= wrSel_d;
            rdSel_q    <= rdSel_d;
            wrRow_q    <= wrRow_d;
            full_q     <= full_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Completion and consume always touch different banks, so both may apply in one cycle
    always_comb begin
        wrSel_d    = wrSel_q;
        rdSel_d    = rdSel_q;
        wrRow_d    = wrRow_q;
        full_d     = full_q;
        frameCnt_d = frameCnt_q;
        if (accept) begin
            if (rowIsLast) begin
                wrRow_d         = '0;
                full_d[wrSel_q] = 1'b1;
                wrSel_d         = !wrSel_q;
            end else begin
                wrRow_d = wrRow_q + RW'(1);
            end
        end
        if (consume) begin
            full_d[rdSel_q] = 1'b0;
            rdSel_d         = !rdSel_q;
            frameCnt_d      = frameCnt_q + 16'd1;
        end
    end

`ifdef MATRIX_ROW_LOADER_LAST_CHECK_EN
    logic [7:0] errCnt_q, errCnt_d;
    logic       errSticky_q, errSticky_d;
    logic       lastMismatch;

    assign lastMismatch = accept && (s_last != rowIsLast);
    assign err_cnt      = errCnt_q;
    assign err_sticky   = errSticky_q;

    // Count framing mismatches, saturating so a broken producer cannot wrap the count
    always_comb begin
        errCnt_d    = errCnt_q;
        errSticky_d = errSticky_q;
        if (lastMismatch) begin
            errSticky_d = 1'b1;
            if (errCnt_q != 8'hFF) begin
                errCnt_d = errCnt_q + 8'd1;
            end
        end
    end

    // Error registers are cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            errCnt_q    <= 8'd0;
            errSticky_q <= 1'b0;
        end else begin
            errCnt_q    <= errCnt_d;
            errSticky_q <= errSticky_d;
        end
    end
`else
    logic unusedLast;

    assign unusedLast = s_last;
    assign err_cnt    = 8'd0;
    assign err_sticky = 1'b0;
`endif

endmodule
